csa_stream_accumulator: RTL and testbench

- Parametrised successor to the fixed 8-bit carry-save adder stage.
- Accepts a stream of WIDTH-bit unsigned operands over a valid/ready handshake and accumulates them in redundant carry-save form, using one CSA row per beat with no carry propagation in the accumulate loop.
- On the group's last beat it resolves the redundant pair with a chunked, multi-cycle carry-propagate adder.
- Presents the final sum, beat count and overflow flag on an output handshake.
- Sits between the partial-product generators and downstream consumers in the Wallace multiplier datapath.

---
 rtl/csa_stream_accumulator_if.sv | 27 ++
 rtl/csa_stream_accumulator.sv | 99 +++++++++
 tb/tb_csa_stream_accumulator.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/csa_stream_accumulator_if.sv
// Operand-in / result-out handshake bundle for the carry-save stream accumulator.
// The accumulator takes the slave side; the producer/consumer side is the master.
interface csa_stream_accumulator_if #(
  parameter int WIDTH     = 8,
  parameter int ACC_WIDTH = 16,
  parameter int COUNT_W   = 8
);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     in_data;
  logic                 in_last;
  logic                 out_valid;
  logic                 out_ready;
  logic [ACC_WIDTH-1:0] out_sum;
  logic [COUNT_W-1:0]   out_count;
  logic                 out_overflow;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_count, out_overflow
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_count, out_overflow
  );
endinterface

// File: rtl/csa_stream_accumulator.sv
// Streams unsigned operands into a carry-save (S, C) pair, one CSA row per beat,
// then resolves the pair with a chunked multi-cycle carry-propagate adder.
module csa_stream_accumulator #(
  parameter int WIDTH     = 8,
  parameter int ACC_WIDTH = 16,
  parameter int CPA_CHUNK = 8,
  parameter int COUNT_W   = 8
) (
  input logic                    clk,
  input logic                    rst,
  csa_stream_accumulator_if.slave bus
);
  localparam int NCHUNK = ACC_WIDTH / CPA_CHUNK;
  localparam int K_W    = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [1:0] {ACCUM, RESOLVE, DONE} state_t;

  state_t               state, state_next;
  logic [ACC_WIDTH-1:0] s, c, result;
  logic                 cin, ovf;
  logic [COUNT_W-1:0]   count;
  logic [K_W-1:0]       k;

  logic [ACC_WIDTH-1:0] x, maj;
  logic [CPA_CHUNK:0]   chunk_sum;
  logic                 beat, last_chunk, handoff;

  assign x          = ACC_WIDTH'(bus.in_data);
  assign maj        = (s & c) | (s & x) | (c & x);
  assign beat       = (state == ACCUM) && bus.in_valid;
  assign last_chunk = (k == K_W'(NCHUNK - 1));
  assign handoff    = (state == DONE) && bus.out_ready;

  // One CPA chunk per cycle; the carry between chunks travels through cin.
  always_comb begin
    chunk_sum = {1'b0, s[int'(k)*CPA_CHUNK +: CPA_CHUNK]}
              + {1'b0, c[int'(k)*CPA_CHUNK +: CPA_CHUNK]}
              + {{CPA_CHUNK{1'b0}}, cin};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ACCUM;
    else     state <= state_next;
  end

  always_comb begin
    // NOTE: default first so every path assigns state_next and no latch is inferred.
    state_next = state;
    unique case (state)
      ACCUM:   if (beat && bus.in_last)  state_next = RESOLVE;
      RESOLVE: if (last_chunk)           state_next = DONE;
      DONE:    if (bus.out_ready)        state_next = ACCUM;
      default:                           state_next = ACCUM;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: non-blocking everywhere here so all registers update from pre-edge values.
      s      <= '0;
      c      <= '0;
      result <= '0;
      cin    <= 1'b0;
      count  <= '0;
      ovf    <= 1'b0;
      k      <= '0;
    end else if (beat) begin
      s     <= s ^ c ^ x;
      c     <= maj << 1;
      ovf   <= ovf | maj[ACC_WIDTH-1];
      if (count != '1) count <= count + 1'b1;
      if (bus.in_last) begin
        k   <= '0;
        cin <= 1'b0;
      end
    end else if (state == RESOLVE) begin
      result[int'(k)*CPA_CHUNK +: CPA_CHUNK] <= chunk_sum[CPA_CHUNK-1:0];
      cin <= chunk_sum[CPA_CHUNK];
      if (last_chunk) begin
        ovf <= ovf | chunk_sum[CPA_CHUNK];
        k   <= '0;
      end else begin
        k   <= k + 1'b1;
      end
    end else if (handoff) begin
      s     <= '0;
      c     <= '0;
      count <= '0;
      ovf   <= 1'b0;
    end
  end

  // Outputs come straight from registers or the state decode only.
  assign bus.in_ready     = (state == ACCUM);
  assign bus.out_valid    = (state == DONE);
  assign bus.out_sum      = result;
  assign bus.out_count    = count;
  assign bus.out_overflow = ovf;
endmodule

// File: tb/tb_csa_stream_accumulator.sv
// Drives directed and randomized operand groups into csa_stream_accumulator and
// compares every cycle against an arithmetic model of the group sum and timeline.
module tb_csa_stream_accumulator;
  localparam int WIDTH     = 8;
  localparam int ACC_WIDTH = 16;
  localparam int CPA_CHUNK = 8;
  localparam int COUNT_W   = 8;
  localparam int NCHUNK    = ACC_WIDTH / CPA_CHUNK;
  localparam longint MODV  = 64'd1 << ACC_WIDTH;
  localparam int CNT_MAX   = (1 << COUNT_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  csa_stream_accumulator_if #(.WIDTH(WIDTH), .ACC_WIDTH(ACC_WIDTH), .COUNT_W(COUNT_W)) ifc ();

  csa_stream_accumulator #(
    .WIDTH(WIDTH), .ACC_WIDTH(ACC_WIDTH), .CPA_CHUNK(CPA_CHUNK), .COUNT_W(COUNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(ifc.slave)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: true group sum as a wide integer plus a simple timeline
  // (taking beats, busy for NCHUNK cycles, holding a result until taken).
  typedef enum int {M_TAKE, M_BUSY, M_HOLD} mode_t;
  mode_t  m_mode;
  longint m_sum;
  int     m_cnt, m_wait;
  longint e_sum;
  int     e_cnt;
  bit     e_ovf;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_mode = M_TAKE; m_sum = 0; m_cnt = 0; m_wait = 0;
    end else begin
      case (m_mode)
        M_TAKE: if (ifc.in_valid) begin
          m_sum += longint'(ifc.in_data);
          m_cnt++;
          if (ifc.in_last) begin
            e_sum  = m_sum % MODV;
            e_ovf  = (m_sum >= MODV);
            e_cnt  = (m_cnt > CNT_MAX) ? CNT_MAX : m_cnt;
            m_wait = NCHUNK;
            m_mode = M_BUSY;
          end
        end
        M_BUSY: begin
          m_wait--;
          if (m_wait == 0) m_mode = M_HOLD;
        end
        M_HOLD: if (ifc.out_ready) begin
          m_sum = 0; m_cnt = 0; m_mode = M_TAKE;
        end
        default: m_mode = M_TAKE;
      endcase
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      check("in_ready", ifc.in_ready, m_mode == M_TAKE);
      check("out_valid", ifc.out_valid, m_mode == M_HOLD);
      if (m_mode == M_HOLD) begin
        check("out_sum", ifc.out_sum, e_sum);
        check("out_count", ifc.out_count, e_cnt);
        check("out_overflow", ifc.out_overflow, e_ovf);
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send_beat(input logic [7:0] d, input bit last);
    int guard = 0;
    ifc.in_valid = 1'b1; ifc.in_data = d; ifc.in_last = last;
    while (ifc.in_ready !== 1'b1 && guard < 400) begin tick(); guard++; end
    if (guard >= 400) check("ready_timeout", 1'b0, 1'b1);
    tick();
    ifc.in_valid = 1'b0; ifc.in_last = 1'b0;
  endtask

  task automatic get_result(output int lat);
    lat = 0;
    while (ifc.out_valid !== 1'b1 && lat < 400) begin tick(); lat++; end
    if (lat >= 400) check("result_timeout", 1'b0, 1'b1);
  endtask

  task automatic take_result();
    ifc.out_ready = 1'b1;
    tick();
    ifc.out_ready = 1'b0;
  endtask

  task automatic expect_result(input string tag, input logic [15:0] sum,
                               input int cnt, input bit ov);
    check({tag, "_sum"}, ifc.out_sum, sum);
    check({tag, "_count"}, ifc.out_count, cnt);
    check({tag, "_ovf"}, ifc.out_overflow, ov);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    #1;
    check("rst_out_valid", ifc.out_valid, 1'b0);
    check("rst_in_ready", ifc.in_ready, 1'b1);
    check("rst_out_sum", ifc.out_sum, 16'h0000);
    tick(); tick();
    #2 rst = 1'b0;
    tick();
  endtask

  initial begin
    int lat;
    logic [15:0] held_sum;
    ifc.in_valid = 1'b0; ifc.in_data = '0; ifc.in_last = 1'b0; ifc.out_ready = 1'b0;

    #3;
    check("reset_out_valid", ifc.out_valid, 1'b0);
    check("reset_in_ready", ifc.in_ready, 1'b1);
    check("reset_out_sum", ifc.out_sum, 16'h0000);
    check("reset_out_count", ifc.out_count, 8'h00);
    check("reset_out_overflow", ifc.out_overflow, 1'b0);
    @(posedge clk); #2 rst = 1'b0;
    tick();

    // Back-to-back 0xFF x3.
    send_beat(8'hFF, 0); send_beat(8'hFF, 0); send_beat(8'hFF, 1);
    get_result(lat);
    check("latency_3xff", lat, NCHUNK);
    expect_result("g3xff", 16'h02FD, 3, 0);
    take_result();

    // Single beat, then a gapped three-beat group.
    send_beat(8'h5A, 1);
    get_result(lat);
    check("latency_single", lat, NCHUNK);
    expect_result("single", 16'h005A, 1, 0);
    take_result();
    send_beat(8'h01, 0); repeat (3) tick();
    send_beat(8'h02, 0); repeat (3) tick();
    send_beat(8'h03, 1);
    get_result(lat);
    expect_result("gapped", 16'h0006, 3, 0);
    take_result();

    // Saturating count and overflow.
    for (int i = 0; i < 300; i++) send_beat(8'hFF, i == 299);
    get_result(lat);
    expect_result("g300", 16'h2AD4, 8'hFF, 1);
    take_result();

    // All-zero group.
    send_beat(8'h00, 0); send_beat(8'h00, 1);
    get_result(lat);
    expect_result("zero", 16'h0000, 2, 0);
    take_result();

    // Backpressure in DONE with a beat waiting on the input.
    send_beat(8'h11, 0); send_beat(8'h22, 1);
    get_result(lat);
    held_sum = ifc.out_sum;
    check("bp_first_sum", held_sum, 16'h0033);
    ifc.in_valid = 1'b1; ifc.in_data = 8'h77; ifc.in_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_hold_valid", ifc.out_valid, 1'b1);
      check("bp_hold_ready", ifc.in_ready, 1'b0);
      check("bp_hold_sum", ifc.out_sum, held_sum);
    end
    ifc.out_ready = 1'b1;
    tick();
    ifc.out_ready = 1'b0;
    tick();
    ifc.in_valid = 1'b0; ifc.in_last = 1'b0;
    get_result(lat);
    expect_result("bp_next", 16'h0077, 1, 0);
    take_result();

    // Reset mid-stream: partial group discarded.
    send_beat(8'h44, 0); send_beat(8'h55, 0);
    pulse_reset();
    send_beat(8'h01, 1);
    get_result(lat);
    expect_result("post_rst", 16'h0001, 1, 0);
    take_result();

    // Reset during the second resolve cycle: no result pulse.
    send_beat(8'h33, 1);
    tick();
    pulse_reset();
    repeat (4) begin
      tick();
      check("abort_no_valid", ifc.out_valid, 1'b0);
    end
    send_beat(8'h10, 1);
    get_result(lat);
    expect_result("after_abort", 16'h0010, 1, 0);
    take_result();

    // Randomized groups with gaps and delayed consumers.
    for (int g = 0; g < 40; g++) begin
      int len;
      bit big;
      big = ($urandom_range(0, 4) == 0);
      len = big ? $urandom_range(250, 300) : $urandom_range(1, 12);
      for (int b = 0; b < len; b++) begin
        if (!big) repeat ($urandom_range(0, 2)) tick();
        send_beat(big ? 8'($urandom_range(200, 255)) : 8'($urandom), b == len - 1);
      end
      get_result(lat);
      check("rand_latency", lat, NCHUNK);
      repeat ($urandom_range(0, 3)) tick();
      take_result();
    end

    repeat (3) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
